// File: rtl/regread_pkg.sv
// regread_pkg: shared sizes, bundle types and operand helpers for the register-read stage
package regread_pkg;
    localparam int IWD  = 4;
    localparam int EWD  = 4;
    localparam int CWD  = 4;
    localparam int PRN  = 128;
    localparam int XLEN = 64;
    localparam int PRW  = $clog2(PRN);

    typedef struct packed {
        logic [15:0] opid;
        logic        redir;
    } com_bundle_t;

    typedef struct packed {
        logic [15:0]      opid;
        logic [1:0][15:0] prsa;
        logic [15:0]      prda;
        logic [3:0]       fu;
    } iss_bundle_t;

    typedef struct packed {
        logic [15:0]     opid;
        logic [15:0]     prda;
        logic [XLEN-1:0] rdval;
    } exe_bundle_t;

    // Field order mirrors iss_bundle_t so an issued op can be concatenated with its operands
    typedef struct packed {
        logic [15:0]           opid;
        logic [1:0][15:0]      prsa;
        logic [15:0]           prda;
        logic [3:0]            fu;
        logic [1:0][XLEN-1:0]  opv;
    } rr_bundle_t;

    // Register index is inside the physical register file
    function automatic logic prn_ok(input logic [15:0] idx);
        return idx <= 16'(PRN - 1);
    endfunction

    // Forward a matching writeback over dflt; the lowest port is applied last so it wins
    function automatic logic [XLEN-1:0] fwd(input exe_bundle_t [EWD-1:0] exe,
                                            input logic [15:0] idx,
                                            input logic [XLEN-1:0] dflt);
        logic [XLEN-1:0] v;
        v = dflt;
        for (int j = EWD - 1; j >= 0; j--)
            if (exe[j].opid[15] && exe[j].prda == idx) v = exe[j].rdval;
        return v;
    endfunction
endpackage

// File: rtl/regread_prf.sv
// regread_prf: physical register file with combinational read ports and prioritised write ports
module regread_prf
    import regread_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [EWD-1:0]                we_i,
    input  logic [EWD-1:0][PRW-1:0]       waddr_i,
    input  logic [EWD-1:0][XLEN-1:0]      wdata_i,
    input  logic [2*IWD-1:0][PRW-1:0]     raddr_i,
    output logic [2*IWD-1:0][XLEN-1:0]    rdata_o
);
    logic [XLEN-1:0] mem_q [PRN];

    // Write ports applied highest first so the lowest port lands last on a collision
    always_ff @(posedge clk) begin
        for (int j = EWD - 1; j >= 0; j--)
            if (we_i[j]) mem_q[waddr_i[j]] <= wdata_i[j];
        if (rst) mem_q[0] <= '0;
    end

    // Unregistered reads; same-cycle writes are bypassed by the caller
    always_comb begin
        for (int p = 0; p < 2 * IWD; p++)
            rdata_o[p] = mem_q[raddr_i[p]];
    end
endmodule

// File: rtl/regread.sv
// regread: register-read stage with PRF, writeback bypass and per-lane valid/ready operand registers
module regread
    import regread_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  com_bundle_t [CWD-1:0]      com_bundle,
    input  iss_bundle_t [IWD-1:0]      iss_bundle,
    output logic [IWD-1:0]             issue,
    input  exe_bundle_t [EWD-1:0]      exe_bundle,
    output rr_bundle_t [IWD-1:0]       rr_bundle,
    input  logic [IWD-1:0]             rr_ready
);
    rr_bundle_t [IWD-1:0]             rr_q, rr_d;
    logic [EWD-1:0]                   we;
    logic [EWD-1:0][PRW-1:0]          waddr;
    logic [EWD-1:0][XLEN-1:0]         wdata;
    logic [2*IWD-1:0][PRW-1:0]        raddr;
    logic [2*IWD-1:0][XLEN-1:0]       rdata;
    logic [IWD-1:0][1:0][XLEN-1:0]    opv_ld, opv_wk;
    logic                             unused_ok;

    regread_prf u_prf (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    // Writeback ports into the PRF; register 0 and out-of-range indices are never written
    always_comb begin
        for (int j = 0; j < EWD; j++) begin
            we[j]    = exe_bundle[j].opid[15] && exe_bundle[j].prda != '0 && prn_ok(exe_bundle[j].prda);
            waddr[j] = exe_bundle[j].prda[PRW-1:0];
            wdata[j] = exe_bundle[j].rdval;
        end
    end

    // Operand values for a fresh load (bypass over PRF) and for a held lane (late writeback wakeup)
    always_comb begin
        for (int i = 0; i < IWD; i++) begin
            for (int k = 0; k < 2; k++) begin
                raddr[2*i+k]  = iss_bundle[i].prsa[k][PRW-1:0];
                opv_ld[i][k]  = (iss_bundle[i].prsa[k] == '0 || !prn_ok(iss_bundle[i].prsa[k])) ? '0
                              : fwd(exe_bundle, iss_bundle[i].prsa[k], rdata[2*i+k]);
                opv_wk[i][k]  = (rr_q[i].prsa[k] == '0 || !prn_ok(rr_q[i].prsa[k])) ? rr_q[i].opv[k]
                              : fwd(exe_bundle, rr_q[i].prsa[k], rr_q[i].opv[k]);
            end
        end
    end

    // Per-lane next state: load on accept, refresh operands while held, otherwise empty
    always_comb begin
        for (int i = 0; i < IWD; i++) begin
            issue[i] = ~rr_q[i].opid[15] | rr_ready[i];
            rr_d[i]  = '0;
            if (iss_bundle[i].opid[15] && issue[i]) begin
                rr_d[i] = {iss_bundle[i], opv_ld[i]};
            end else if (rr_q[i].opid[15] && !rr_ready[i]) begin
                rr_d[i]     = rr_q[i];
                rr_d[i].opv = opv_wk[i];
            end
        end
    end

    // Lane registers; reset and redirect both drop every lane
    always_ff @(posedge clk) begin
        rr_q <= (rst || com_bundle[0].redir) ? '0 : rr_d;
    end

    assign rr_bundle = rr_q;

    assign unused_ok = ^{com_bundle[CWD-1:1], com_bundle[0].opid,
                         exe_bundle[0].opid[14:0], exe_bundle[1].opid[14:0],
                         exe_bundle[2].opid[14:0], exe_bundle[3].opid[14:0]};
endmodule

// File: tb/tb_regread.sv
// tb_regread: directed and randomized self-checking bench for regread
module tb_regread;
    import regread_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    com_bundle_t [CWD-1:0]  com_bundle;
    iss_bundle_t [IWD-1:0]  iss_bundle;
    logic [IWD-1:0]         issue;
    exe_bundle_t [EWD-1:0]  exe_bundle;
    rr_bundle_t [IWD-1:0]   rr_bundle;
    logic [IWD-1:0]         rr_ready;

    int n_chk  = 0;
    int n_pass = 0;
    logic [XLEN-1:0] prf_m [16];
    iss_bundle_t q [IWD][$];

    regread dut (
        .clk        (clk),
        .rst        (rst),
        .com_bundle (com_bundle),
        .iss_bundle (iss_bundle),
        .issue      (issue),
        .exe_bundle (exe_bundle),
        .rr_bundle  (rr_bundle),
        .rr_ready   (rr_ready)
    );

    always #5 clk = ~clk;

    function automatic iss_bundle_t mk_iss(input logic [14:0] id, input logic [15:0] s1, input logic [15:0] s0);
        iss_bundle_t b;
        b.opid    = {1'b1, id};
        b.prsa[1] = s1;
        b.prsa[0] = s0;
        b.prda    = {9'd0, id[6:0]};
        b.fu      = id[3:0];
        return b;
    endfunction

    function automatic exe_bundle_t mk_exe(input logic [15:0] rd, input logic [XLEN-1:0] v);
        exe_bundle_t e;
        e.opid  = 16'h8000;
        e.prda  = rd;
        e.rdval = v;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        com_bundle = '0;
        iss_bundle = '0;
        exe_bundle = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rr_ready = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < IWD; i++) begin
            n_chk++;
            if (rr_bundle[i] !== '0) $display("FAIL reset_lane%0d got %h want 0", i, rr_bundle[i]);
            else n_pass++;
        end
        n_chk++;
        if (issue !== 4'hF) $display("FAIL reset_issue got %h want f", issue);
        else n_pass++;
    endtask

    task automatic test_read();
        exe_bundle[0] = mk_exe(16'd5, 64'hAA);
        tick();
        idle();
        iss_bundle[0] = mk_iss(15'd1, 16'd5, 16'd0);
        #1;
        n_chk++;
        if (issue[0] !== 1'b1) $display("FAIL read_issue got %b want 1", issue[0]);
        else n_pass++;
        tick();
        idle();
        n_chk++;
        if (rr_bundle[0].opid !== 16'h8001 || rr_bundle[0].opv[1] !== 64'hAA || rr_bundle[0].opv[0] !== 64'h0)
            $display("FAIL read_prf got %h/%h/%h want 8001/aa/0", rr_bundle[0].opid, rr_bundle[0].opv[1], rr_bundle[0].opv[0]);
        else n_pass++;
        rr_ready = '1;
        tick();
    endtask

    task automatic test_bypass();
        rr_ready = '1;
        iss_bundle[0] = mk_iss(15'd2, 16'd5, 16'd7);
        exe_bundle[1] = mk_exe(16'd7, 64'h1234);
        tick();
        idle();
        n_chk++;
        if (rr_bundle[0].opv[0] !== 64'h1234 || rr_bundle[0].opv[1] !== 64'hAA)
            $display("FAIL bypass got %h/%h want aa/1234", rr_bundle[0].opv[1], rr_bundle[0].opv[0]);
        else n_pass++;
        iss_bundle[0] = mk_iss(15'd3, 16'd0, 16'd7);
        tick();
        idle();
        n_chk++;
        if (rr_bundle[0].opv[0] !== 64'h1234) $display("FAIL bypass_commit got %h want 1234", rr_bundle[0].opv[0]);
        else n_pass++;
        tick();
    endtask

    task automatic test_hold();
        rr_ready = '1;
        exe_bundle[0] = mk_exe(16'd9, 64'h11);
        tick();
        idle();
        rr_ready[1] = 1'b0;
        iss_bundle[1] = mk_iss(15'd4, 16'd9, 16'd5);
        tick();
        n_chk++;
        if (rr_bundle[1].opid !== 16'h8004 || rr_bundle[1].opv[1] !== 64'h11 || rr_bundle[1].opv[0] !== 64'hAA)
            $display("FAIL hold_load got %h/%h/%h want 8004/11/aa", rr_bundle[1].opid, rr_bundle[1].opv[1], rr_bundle[1].opv[0]);
        else n_pass++;
        iss_bundle[1] = mk_iss(15'd5, 16'd9, 16'd9);
        iss_bundle[0] = mk_iss(15'd6, 16'd7, 16'd0);
        #1;
        n_chk++;
        if (issue[1] !== 1'b0) $display("FAIL hold_issue got %b want 0", issue[1]);
        else n_pass++;
        tick();
        iss_bundle[0] = '0;
        n_chk++;
        if (rr_bundle[1].opid !== 16'h8004 || rr_bundle[1].opv[1] !== 64'h11)
            $display("FAIL hold_stable got %h/%h want 8004/11", rr_bundle[1].opid, rr_bundle[1].opv[1]);
        else n_pass++;
        n_chk++;
        if (rr_bundle[0].opid !== 16'h8006 || rr_bundle[0].opv[1] !== 64'h1234)
            $display("FAIL hold_indep got %h/%h want 8006/1234", rr_bundle[0].opid, rr_bundle[0].opv[1]);
        else n_pass++;
        exe_bundle[2] = mk_exe(16'd9, 64'h55);
        tick();
        idle();
        #1;
        n_chk++;
        if (issue[1] !== 1'b0 || rr_bundle[1].opid !== 16'h8004 || rr_bundle[1].opv[1] !== 64'h55)
            $display("FAIL hold_wakeup got %b/%h/%h want 0/8004/55", issue[1], rr_bundle[1].opid, rr_bundle[1].opv[1]);
        else n_pass++;
        rr_ready[1] = 1'b1;
        #1;
        n_chk++;
        if (issue[1] !== 1'b1 || rr_bundle[1].opv[1] !== 64'h55)
            $display("FAIL hold_release got %b/%h want 1/55", issue[1], rr_bundle[1].opv[1]);
        else n_pass++;
        tick();
        n_chk++;
        if (rr_bundle[1].opid[15] !== 1'b0) $display("FAIL hold_empty got %b want 0", rr_bundle[1].opid[15]);
        else n_pass++;
    endtask

    task automatic test_priority();
        rr_ready = '1;
        exe_bundle[0] = mk_exe(16'd3, 64'h1);
        exe_bundle[2] = mk_exe(16'd3, 64'h2);
        iss_bundle[2] = mk_iss(15'd7, 16'd0, 16'd3);
        tick();
        idle();
        n_chk++;
        if (rr_bundle[2].opv[0] !== 64'h1) $display("FAIL prio_bypass got %h want 1", rr_bundle[2].opv[0]);
        else n_pass++;
        iss_bundle[2] = mk_iss(15'd8, 16'd3, 16'd0);
        tick();
        idle();
        n_chk++;
        if (rr_bundle[2].opv[1] !== 64'h1) $display("FAIL prio_prf got %h want 1", rr_bundle[2].opv[1]);
        else n_pass++;
        tick();
    endtask

    task automatic test_redirect();
        rr_ready = '0;
        for (int i = 0; i < IWD; i++) iss_bundle[i] = mk_iss(15'(10 + i), 16'd5, 16'd7);
        tick();
        for (int i = 0; i < IWD; i++) begin
            n_chk++;
            if (rr_bundle[i].opid !== 16'(16'h800A + i))
                $display("FAIL redir_fill%0d got %h want %h", i, rr_bundle[i].opid, 16'(16'h800A + i));
            else n_pass++;
        end
        com_bundle[0].redir = 1'b1;
        for (int i = 0; i < IWD; i++) iss_bundle[i] = mk_iss(15'(20 + i), 16'd5, 16'd5);
        exe_bundle[0] = mk_exe(16'd11, 64'h77);
        tick();
        idle();
        #1;
        for (int i = 0; i < IWD; i++) begin
            n_chk++;
            if (rr_bundle[i].opid[15] !== 1'b0) $display("FAIL redir_clear%0d got %b want 0", i, rr_bundle[i].opid[15]);
            else n_pass++;
        end
        n_chk++;
        if (issue !== 4'hF) $display("FAIL redir_issue got %h want f", issue);
        else n_pass++;
        rr_ready = '1;
        iss_bundle[0] = mk_iss(15'd30, 16'd11, 16'd5);
        tick();
        idle();
        n_chk++;
        if (rr_bundle[0].opv[1] !== 64'h77 || rr_bundle[0].opv[0] !== 64'hAA)
            $display("FAIL redir_prf got %h/%h want 77/aa", rr_bundle[0].opv[1], rr_bundle[0].opv[0]);
        else n_pass++;
        tick();
    endtask

    task automatic test_zero();
        rr_ready = '1;
        exe_bundle[0] = mk_exe(16'd0, 64'hFF);
        iss_bundle[3] = mk_iss(15'd31, 16'd0, 16'd0);
        tick();
        idle();
        n_chk++;
        if (rr_bundle[3].opv !== '0) $display("FAIL zero_bypass got %h want 0", rr_bundle[3].opv);
        else n_pass++;
        iss_bundle[3] = mk_iss(15'd32, 16'd0, 16'd0);
        tick();
        idle();
        n_chk++;
        if (rr_bundle[3].opv !== '0) $display("FAIL zero_prf got %h want 0", rr_bundle[3].opv);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_stall();
        rr_ready = '0;
        iss_bundle[0] = mk_iss(15'd33, 16'd5, 16'd5);
        tick();
        idle();
        n_chk++;
        if (rr_bundle[0].opid !== 16'h8021) $display("FAIL rststall_load got %h want 8021", rr_bundle[0].opid);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_chk++;
        if (rr_bundle[0] !== '0 || issue !== 4'hF)
            $display("FAIL rststall_drop got %h/%h want 0/f", rr_bundle[0].opid, issue);
        else n_pass++;
    endtask

    task automatic test_random();
        rr_bundle_t e;
        int id;
        id = 100;
        rr_ready = '1;
        idle();
        prf_m[0] = '0;
        for (int g = 0; g < 4; g++) begin
            for (int j = 0; j < EWD; j++) begin
                if (g * 4 + j != 0) begin
                    prf_m[g*4+j] = {$urandom, $urandom};
                    exe_bundle[j] = mk_exe(16'(g * 4 + j), prf_m[g*4+j]);
                end
            end
            tick();
            idle();
        end
        for (int c = 0; c < 420; c++) begin
            idle();
            rr_ready = (c < 400) ? 4'($urandom) : 4'hF;
            for (int i = 0; i < IWD; i++)
                if (c < 400 && $urandom_range(0, 3) != 0) begin
                    iss_bundle[i] = mk_iss(15'(id), 16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)));
                    id++;
                end
            for (int j = 0; j < EWD; j++)
                if (c < 400 && $urandom_range(0, 1) != 0)
                    exe_bundle[j] = mk_exe(16'($urandom_range(0, 15)), {$urandom, $urandom});
            #1;
            for (int i = 0; i < IWD; i++) begin
                logic acc;
                acc = (q[i].size() == 0) || rr_ready[i];
                n_chk++;
                if (issue[i] !== acc || rr_bundle[i].opid[15] !== (q[i].size() != 0))
                    $display("FAIL rand_state c%0d lane%0d got issue %b valid %b want %b %b",
                             c, i, issue[i], rr_bundle[i].opid[15], acc, q[i].size() != 0);
                else n_pass++;
                if (q[i].size() != 0) begin
                    e = {q[i][0], prf_m[q[i][0].prsa[1][3:0]], prf_m[q[i][0].prsa[0][3:0]]};
                    n_chk++;
                    if (rr_bundle[i] !== e) $display("FAIL rand_data c%0d lane%0d got %h want %h", c, i, rr_bundle[i], e);
                    else n_pass++;
                    if (rr_ready[i]) void'(q[i].pop_front());
                end
                if (iss_bundle[i].opid[15] && acc) q[i].push_back(iss_bundle[i]);
            end
            for (int j = EWD - 1; j >= 0; j--)
                if (exe_bundle[j].opid[15] && exe_bundle[j].prda != 16'd0)
                    prf_m[exe_bundle[j].prda[3:0]] = exe_bundle[j].rdval;
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_read();
        test_bypass();
        test_hold();
        test_priority();
        test_redirect();
        test_zero();
        test_reset_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
